// File: rtl/fsm_codes_pkg.sv
// Shared encodings for the sequencer state-code interface and its monitor.
package fsm_codes_pkg;

  localparam int unsigned CODE_W = 2;

  localparam logic [CODE_W-1:0] CODE_INV = 2'b00;
  localparam logic [CODE_W-1:0] CODE_S0  = 2'b01;
  localparam logic [CODE_W-1:0] CODE_S1  = 2'b10;
  localparam logic [CODE_W-1:0] CODE_S2  = 2'b11;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_CODE  = 2'b01,
    ERR_TRANS = 2'b10
  } err_t;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    LOCKED = 2'b01,
    FAULT  = 2'b10
  } mon_state_t;

endpackage

// File: rtl/fsm_trans_check.sv
// Combinational classifier of one code pair against the sequencer's transition graph.
module fsm_trans_check
  import fsm_codes_pkg::*;
(
  input  logic [CODE_W-1:0] prev_code,
  input  logic [CODE_W-1:0] code,
  output logic              legal,
  output logic              in_bit,
  output logic              in_known,
  output logic              is_loop,
  output err_t              err_kind
);

  always_comb begin
    legal    = 1'b0;
    in_bit   = 1'b0;
    in_known = 1'b0;
    is_loop  = 1'b0;
    err_kind = ERR_NONE;

    case ({prev_code, code})
      {CODE_S0, CODE_S1}: legal = 1'b1;
      {CODE_S1, CODE_S1}: begin legal = 1'b1; in_known = 1'b1; in_bit = 1'b0; end
      {CODE_S1, CODE_S2}: begin legal = 1'b1; in_known = 1'b1; in_bit = 1'b1; end
      {CODE_S2, CODE_S2}: begin legal = 1'b1; in_known = 1'b1; in_bit = 1'b0; end
      {CODE_S2, CODE_S0}: begin legal = 1'b1; in_known = 1'b1; in_bit = 1'b1; is_loop = 1'b1; end
      default: ;
    endcase

    // An invalid code takes precedence over the transition verdict.
    if (code == CODE_INV) begin
      legal    = 1'b0;
      in_known = 1'b0;
      is_loop  = 1'b0;
      err_kind = ERR_CODE;
    end else if (!legal) begin
      err_kind = ERR_TRANS;
    end
  end

endmodule

// File: rtl/fsm_code_monitor.sv
// Monitors the sequencer state-code stream: lock tracking, error capture,
// input-bit recovery and loop counting.
module fsm_code_monitor
  import fsm_codes_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_LEN = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              code_vld,
  input  logic [CODE_W-1:0] code,
  input  logic              err_clr,
  output logic              locked,
  output logic              in_rec,
  output logic              in_rec_vld,
  output logic              err_pulse,
  output logic              err_flag,
  output logic [1:0]        err_type,
  output logic [CNT_W-1:0]  loop_cnt,
  output logic [CODE_W-1:0] cur_code
);

  localparam int unsigned LCNT_W = 4;

  mon_state_t        state_q, state_d, state_eff;
  logic [LCNT_W-1:0] lock_cnt_q, lock_cnt_d, lock_next;
  logic [CODE_W-1:0] prev_code_q, prev_code_d;
  logic              prev_vld_q, prev_vld_d;

  logic              locked_d, in_rec_d, in_rec_vld_d, err_pulse_d, err_flag_d;
  logic [1:0]        err_type_d;
  logic [CNT_W-1:0]  loop_cnt_d;
  logic [CODE_W-1:0] cur_code_d;

  logic legal, in_bit, in_known, is_loop;
  err_t err_kind;

  fsm_trans_check u_check (
    .prev_code (prev_code_q),
    .code      (code),
    .legal     (legal),
    .in_bit    (in_bit),
    .in_known  (in_known),
    .is_loop   (is_loop),
    .err_kind  (err_kind)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= HUNT;
      lock_cnt_q  <= '0;
      prev_code_q <= CODE_INV;
      prev_vld_q  <= 1'b0;
      locked      <= 1'b0;
      in_rec      <= 1'b0;
      in_rec_vld  <= 1'b0;
      err_pulse   <= 1'b0;
      err_flag    <= 1'b0;
      err_type    <= ERR_NONE;
      loop_cnt    <= '0;
      cur_code    <= CODE_INV;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      prev_code_q <= prev_code_d;
      prev_vld_q  <= prev_vld_d;
      locked      <= locked_d;
      in_rec      <= in_rec_d;
      in_rec_vld  <= in_rec_vld_d;
      err_pulse   <= err_pulse_d;
      err_flag    <= err_flag_d;
      err_type    <= err_type_d;
      loop_cnt    <= loop_cnt_d;
      cur_code    <= cur_code_d;
    end
  end

  always_comb begin
    state_eff    = state_q;
    lock_cnt_d   = lock_cnt_q;
    prev_code_d  = prev_code_q;
    prev_vld_d   = prev_vld_q;
    in_rec_d     = in_rec;
    in_rec_vld_d = 1'b0;
    err_pulse_d  = 1'b0;
    err_flag_d   = err_flag;
    err_type_d   = err_type;
    loop_cnt_d   = loop_cnt;
    cur_code_d   = cur_code;
    lock_next    = '0;

    // A clear leaving FAULT takes effect before this cycle's sample is judged.
    if (err_clr) begin
      err_flag_d = 1'b0;
      if (state_q == FAULT) begin
        state_eff  = HUNT;
        lock_cnt_d = '0;
      end
    end
    state_d = state_eff;

    if (code_vld) begin
      cur_code_d = code;
      if (!prev_vld_q) begin
        prev_code_d = code;
        prev_vld_d  = (code != CODE_INV);
      end else begin
        if (err_kind == ERR_CODE) prev_vld_d = 1'b0;
        else                      prev_code_d = code;

        if (legal && in_known) begin
          in_rec_vld_d = 1'b1;
          in_rec_d     = in_bit;
        end

        lock_next = lock_cnt_d + LCNT_W'(1);
        case (state_eff)
          HUNT: begin
            if (!legal) begin
              lock_cnt_d = '0;
            end else if (lock_next == LCNT_W'(LOCK_LEN)) begin
              state_d    = LOCKED;
              lock_cnt_d = '0;
            end else begin
              lock_cnt_d = lock_next;
            end
          end
          LOCKED: begin
            if (!legal) begin
              state_d     = FAULT;
              err_pulse_d = 1'b1;
              err_flag_d  = 1'b1;
              err_type_d  = err_kind;
            end else if (is_loop && (loop_cnt != {CNT_W{1'b1}})) begin
              loop_cnt_d = loop_cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end

    locked_d = (state_d == LOCKED);
  end

endmodule

// File: tb/tb_fsm_code_monitor.sv
// Directed self-checking bench for fsm_code_monitor (LOCK_LEN=2, CNT_W=2 and 8).
module tb_fsm_code_monitor;

  logic       clk = 1'b0;
  logic       clr, code_vld, err_clr;
  logic [1:0] code;

  logic       locked, in_rec, in_rec_vld, err_pulse, err_flag;
  logic [1:0] err_type, loop_cnt, cur_code;

  logic       locked8, in_rec8, in_rec_vld8, err_pulse8, err_flag8;
  logic [1:0] err_type8, cur_code8;
  logic [7:0] loop_cnt8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fsm_code_monitor #(.CNT_W(2), .LOCK_LEN(2)) dut (
    .clk(clk), .clr(clr), .code_vld(code_vld), .code(code), .err_clr(err_clr),
    .locked(locked), .in_rec(in_rec), .in_rec_vld(in_rec_vld), .err_pulse(err_pulse),
    .err_flag(err_flag), .err_type(err_type), .loop_cnt(loop_cnt), .cur_code(cur_code)
  );

  fsm_code_monitor #(.CNT_W(8), .LOCK_LEN(2)) dut8 (
    .clk(clk), .clr(clr), .code_vld(code_vld), .code(code), .err_clr(err_clr),
    .locked(locked8), .in_rec(in_rec8), .in_rec_vld(in_rec_vld8), .err_pulse(err_pulse8),
    .err_flag(err_flag8), .err_type(err_type8), .loop_cnt(loop_cnt8), .cur_code(cur_code8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample outputs 1 time unit after the edge.
  task automatic cyc(input logic r, input logic v, input logic [1:0] c, input logic ec);
    clr = r; code_vld = v; code = c; err_clr = ec;
    @(posedge clk);
    #1;
    clr = 1'b0; code_vld = 1'b0; err_clr = 1'b0;
  endtask

  task automatic samp(input logic [1:0] c);
    cyc(1'b0, 1'b1, c, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".locked"},   32'(locked),     32'd0);
    check({tag, ".in_rec"},   32'(in_rec),     32'd0);
    check({tag, ".rec_vld"},  32'(in_rec_vld), 32'd0);
    check({tag, ".pulse"},    32'(err_pulse),  32'd0);
    check({tag, ".flag"},     32'(err_flag),   32'd0);
    check({tag, ".type"},     32'(err_type),   32'd0);
    check({tag, ".loop"},     32'(loop_cnt),   32'd0);
    check({tag, ".loop8"},    32'(loop_cnt8),  32'd0);
    check({tag, ".cur"},      32'(cur_code),   32'd0);
  endtask

  initial begin
    clr = 1'b1; code_vld = 1'b0; code = 2'b00; err_clr = 1'b0;

    // Reset, including a valid sample presented during reset.
    cyc(1'b1, 1'b1, 2'b11, 1'b1);
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    check_zero("rst");

    // Lock and recover.
    samp(2'b01);
    check("s1.cur", 32'(cur_code), 32'h1);
    check("s1.vld", 32'(in_rec_vld), 32'd0);
    check("s1.lock", 32'(locked), 32'd0);
    samp(2'b10);
    check("s2.vld", 32'(in_rec_vld), 32'd0);
    check("s2.lock", 32'(locked), 32'd0);
    samp(2'b10);
    check("s3.lock", 32'(locked), 32'd1);
    check("s3.vld", 32'(in_rec_vld), 32'd1);
    check("s3.rec", 32'(in_rec), 32'd0);
    samp(2'b11);
    check("s4.vld", 32'(in_rec_vld), 32'd1);
    check("s4.rec", 32'(in_rec), 32'd1);
    samp(2'b01);
    check("s5.vld", 32'(in_rec_vld), 32'd1);
    check("s5.rec", 32'(in_rec), 32'd1);
    check("s5.loop", 32'(loop_cnt), 32'd1);

    // Illegal transition S0->S2 while locked.
    samp(2'b11);
    check("ill.pulse", 32'(err_pulse), 32'd1);
    check("ill.type", 32'(err_type), 32'h2);
    check("ill.flag", 32'(err_flag), 32'd1);
    check("ill.lock", 32'(locked), 32'd0);
    check("ill.vld", 32'(in_rec_vld), 32'd0);
    cyc(1'b0, 1'b0, 2'b00, 1'b0);
    check("ill.pulse1", 32'(err_pulse), 32'd0);
    check("ill.flag1", 32'(err_flag), 32'd1);

    // Clear from FAULT, then relock; loop in HUNT is not counted.
    cyc(1'b0, 1'b0, 2'b00, 1'b1);
    check("clr.flag", 32'(err_flag), 32'd0);
    check("clr.type", 32'(err_type), 32'h2);
    samp(2'b01);
    check("rl1.lock", 32'(locked), 32'd0);
    check("rl1.loop", 32'(loop_cnt), 32'd1);
    samp(2'b10);
    check("rl2.lock", 32'(locked), 32'd1);

    // Invalid code while locked, then clear together with another invalid sample.
    samp(2'b00);
    check("inv.type", 32'(err_type), 32'h1);
    check("inv.pulse", 32'(err_pulse), 32'd1);
    check("inv.flag", 32'(err_flag), 32'd1);
    check("inv.lock", 32'(locked), 32'd0);
    cyc(1'b0, 1'b1, 2'b00, 1'b1);
    check("invc.flag", 32'(err_flag), 32'd0);
    check("invc.lock", 32'(locked), 32'd0);
    check("invc.pulse", 32'(err_pulse), 32'd0);
    samp(2'b01);
    check("inv1.lock", 32'(locked), 32'd0);
    samp(2'b10);
    check("inv2.lock", 32'(locked), 32'd0);
    samp(2'b11);
    check("inv3.lock", 32'(locked), 32'd1);

    // Error in LOCKED together with err_clr: the error wins.
    samp(2'b11);
    check("s22.rec", 32'(in_rec), 32'd0);
    check("s22.vld", 32'(in_rec_vld), 32'd1);
    cyc(1'b0, 1'b1, 2'b10, 1'b1);
    check("errw.flag", 32'(err_flag), 32'd1);
    check("errw.pulse", 32'(err_pulse), 32'd1);
    check("errw.type", 32'(err_type), 32'h2);
    // Clear in FAULT with a classified illegal sample (S1->S0): clear wins.
    cyc(1'b0, 1'b1, 2'b01, 1'b1);
    check("clrw.flag", 32'(err_flag), 32'd0);
    check("clrw.pulse", 32'(err_pulse), 32'd0);
    check("clrw.lock", 32'(locked), 32'd0);
    samp(2'b10);
    check("clrw1.lock", 32'(locked), 32'd0);
    samp(2'b11);
    check("clrw2.lock", 32'(locked), 32'd1);

    // Gaps inside LOCKED.
    samp(2'b01);
    check("gap.loop", 32'(loop_cnt), 32'd2);
    samp(2'b10);
    check("gap.s0s1", 32'(in_rec_vld), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 2'b11, 1'b0);
      check("gap.vld", 32'(in_rec_vld), 32'd0);
      check("gap.pulse", 32'(err_pulse), 32'd0);
      check("gap.lock", 32'(locked), 32'd1);
    end
    samp(2'b11);
    check("gapend.rec", 32'(in_rec), 32'd1);
    check("gapend.vld", 32'(in_rec_vld), 32'd1);
    check("gapend.lock", 32'(locked), 32'd1);

    // Reset mid-operation from FAULT with loop_cnt=2 and err_flag=1.
    samp(2'b00);
    check("pre.flag", 32'(err_flag), 32'd1);
    check("pre.loop", 32'(loop_cnt), 32'd2);
    cyc(1'b1, 1'b1, 2'b01, 1'b1);
    check_zero("mid");
    samp(2'b01);
    check("post1.vld", 32'(in_rec_vld), 32'd0);
    check("post1.cur", 32'(cur_code), 32'h1);
    samp(2'b10);
    check("post2.lock", 32'(locked), 32'd0);
    samp(2'b10);
    check("post3.lock", 32'(locked), 32'd1);

    // Saturation: five loops give 1,2,3,3,3 at CNT_W=2 and 1..5 at CNT_W=8.
    samp(2'b11);
    samp(2'b01);
    check("sat.loop0", 32'(loop_cnt), 32'd1);
    check("sat8.loop0", 32'(loop_cnt8), 32'd1);
    for (int k = 2; k <= 5; k++) begin
      samp(2'b10);
      samp(2'b11);
      samp(2'b01);
      check("sat.loop", 32'(loop_cnt), (k > 3) ? 32'd3 : 32'(k));
      check("sat8.loop", 32'(loop_cnt8), 32'(k));
      check("sat.lock", 32'(locked), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
